// File: rtl/dump_fsm.sv
// Output-stage controller: streams squeezed rate blocks from the PISO buffer to the sink.
// Optional backpressure counter enabled by defining DUMP_FSM_STALL_CNT_EN.
module dump_fsm #(
    parameter int W             = 64,
    parameter int OUT_LEN_W     = 32,
    parameter int RATE128_WORDS = 21,
    parameter int RATE256_WORDS = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [OUT_LEN_W-1:0] output_size,
    input  logic                 output_buffer_ready,
    output logic                 buffer_consumed,
    output logic                 squeeze_request,
    output logic                 shift_enable,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 last_out,
    output logic [$clog2(W):0]   out_bits,
    output logic                 done,
    output logic [31:0]          stall_cycles
);

    localparam int OB_W = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_BUFFER = 2'd1,
        DUMP        = 2'd2,
        DONE        = 2'd3
    } state_t;

    state_t                r_state;
    logic [OUT_LEN_W-1:0]  r_remaining;
    logic [4:0]            r_word_idx;
    logic                  r_mode;

    logic [4:0]            w_rate;
    logic                  w_in_dump;
    logic                  w_xfer;
    logic                  w_full_word;
    logic                  w_block_end;
    logic [OUT_LEN_W-1:0]  w_step;

    assign w_rate      = r_mode ? 5'(RATE256_WORDS) : 5'(RATE128_WORDS);
    assign w_in_dump   = (r_state == DUMP);
    assign w_xfer      = w_in_dump && ready_in;
    assign w_full_word = (r_remaining >= OUT_LEN_W'(W));
    assign w_block_end = (r_word_idx == (w_rate - 5'd1));
    // Saturating step: never take more than what is left.
    assign w_step      = w_full_word ? OUT_LEN_W'(W) : r_remaining;

    assign valid_out       = w_in_dump;
    assign shift_enable    = w_xfer;
    assign last_out        = w_in_dump && (r_remaining <= OUT_LEN_W'(W));
    assign out_bits        = w_in_dump ? (w_full_word ? OB_W'(W) : r_remaining[OB_W-1:0]) : '0;
    assign buffer_consumed = w_xfer && (last_out || w_block_end);
    assign squeeze_request = w_xfer && !last_out && w_block_end;
    assign done            = (r_state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_word_idx  <= '0;
            r_mode      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode      <= mode;
                        r_remaining <= output_size;
                        r_state     <= (output_size == '0) ? DONE : WAIT_BUFFER;
                    end
                end
                WAIT_BUFFER: begin
                    if (output_buffer_ready) begin
                        r_word_idx <= '0;
                        r_state    <= DUMP;
                    end
                end
                DUMP: begin
                    if (ready_in) begin
                        r_word_idx  <= r_word_idx + 5'd1;
                        r_remaining <= r_remaining - w_step;
                        if (last_out) begin
                            r_state <= DONE;
                        end else if (w_block_end) begin
                            r_state <= WAIT_BUFFER;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef DUMP_FSM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if (valid_out && !ready_in && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dump_fsm.sv
// Self-checking bench for dump_fsm: randomized sink/permutation behaviour against a
// word-count reference model of the output stream.
module tb_dump_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] output_size;
    logic        output_buffer_ready;
    logic        buffer_consumed;
    logic        squeeze_request;
    logic        shift_enable;
    logic        valid_out;
    logic        ready_in;
    logic        last_out;
    logic [6:0]  out_bits;
    logic        done;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_stall = '0;

    dump_fsm dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .mode                (mode),
        .output_size         (output_size),
        .output_buffer_ready (output_buffer_ready),
        .buffer_consumed     (buffer_consumed),
        .squeeze_request     (squeeze_request),
        .shift_enable        (shift_enable),
        .valid_out           (valid_out),
        .ready_in            (ready_in),
        .last_out            (last_out),
        .out_bits            (out_bits),
        .done                (done),
        .stall_cycles        (stall_cycles)
    );

    always #5 clk = ~clk;

    // rmode: 0 = sink always ready, 1 = random ready, 2 = pattern 1,0,0,1 then ready
    task automatic run_op(input logic md, input int unsigned size, input int rmode,
                          input bit stray, input string name);
        int unsigned n, rate, k, budget, delay, pat_i, e_bits;
        bit have_blk, waiting, obr_q, done_pend, finished, xfer, e_last, e_end;
        int pat[4] = '{1, 0, 0, 1};
        n = (size + 63) / 64;
        rate = md ? 17 : 21;
        k = 0;
        @(negedge clk);
        start = 1'b1;
        mode = md;
        output_size = size;
        output_buffer_ready = 1'b0;
        ready_in = 1'($urandom_range(0, 1));
        m_stall = '0;
        waiting = (n != 0);
        done_pend = (n == 0);
        have_blk = 1'b0;
        obr_q = 1'b0;
        delay = $urandom_range(0, 3);
        pat_i = 0;
        finished = 1'b0;
        budget = n * 8 + 40;
        for (int cyc = 0; cyc < int'(budget) && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (stray && have_blk && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
                mode = 1'($urandom_range(0, 1));
                output_size = $urandom;
            end
            case (rmode)
                0: ready_in = 1'b1;
                1: ready_in = 1'($urandom_range(0, 1));
                default: ready_in = (have_blk && pat_i < 4) ? 1'(pat[pat_i]) : 1'b1;
            endcase
            if (waiting && !obr_q) begin
                if (delay == 0) obr_q = 1'b1;
                else delay--;
            end
            output_buffer_ready = obr_q;
            #1;
            xfer = have_blk && ready_in;
            if (have_blk) begin
                e_bits = (size - 64 * k >= 64) ? 64 : size - 64 * k;
                e_last = (k == n - 1);
                e_end  = ((k % rate) == rate - 1);
            end else begin
                e_bits = 0;
                e_last = 1'b0;
                e_end  = 1'b0;
            end
            checks++;
            if (valid_out !== have_blk) begin
                errors++;
                $display("FAIL %s valid_out word=%0d got=%b exp=%b", name, k, valid_out, have_blk);
            end
            checks++;
            if (shift_enable !== xfer) begin
                errors++;
                $display("FAIL %s shift_enable word=%0d got=%b exp=%b", name, k, shift_enable, xfer);
            end
            checks++;
            if (out_bits !== 7'(e_bits)) begin
                errors++;
                $display("FAIL %s out_bits word=%0d got=%0d exp=%0d", name, k, out_bits, e_bits);
            end
            checks++;
            if (last_out !== e_last) begin
                errors++;
                $display("FAIL %s last_out word=%0d got=%b exp=%b", name, k, last_out, e_last);
            end
            checks++;
            if (buffer_consumed !== (xfer && (e_last || e_end))) begin
                errors++;
                $display("FAIL %s buffer_consumed word=%0d got=%b exp=%b", name, k,
                         buffer_consumed, xfer && (e_last || e_end));
            end
            checks++;
            if (squeeze_request !== (xfer && !e_last && e_end)) begin
                errors++;
                $display("FAIL %s squeeze_request word=%0d got=%b exp=%b", name, k,
                         squeeze_request, xfer && !e_last && e_end);
            end
            checks++;
            if (done !== done_pend) begin
                errors++;
                $display("FAIL %s done word=%0d got=%b exp=%b", name, k, done, done_pend);
            end
            checks++;
`ifdef DUMP_FSM_STALL_CNT_EN
            if (stall_cycles !== m_stall) begin
                errors++;
                $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stall_cycles, m_stall);
            end
`else
            if (stall_cycles !== 32'd0) begin
                errors++;
                $display("FAIL %s stall_cycles got=%0d exp=0", name, stall_cycles);
            end
`endif
            if (done_pend) finished = 1'b1;
            if (have_blk && !ready_in && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (rmode == 2 && have_blk) pat_i++;
            done_pend = 1'b0;
            if (waiting && obr_q) begin
                waiting = 1'b0;
                have_blk = 1'b1;
            end else if (xfer) begin
                k++;
                if (e_last) begin
                    have_blk = 1'b0;
                    done_pend = 1'b1;
                    obr_q = 1'b0;
                end else if (e_end) begin
                    have_blk = 1'b0;
                    waiting = 1'b1;
                    obr_q = 1'b0;
                    delay = $urandom_range(0, 3);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout waiting for done got_words=%0d exp_words=%0d", name, k, n);
        end
        checks++;
        if (k !== n) begin
            errors++;
            $display("FAIL %s transfer_count got=%0d exp=%0d", name, k, n);
        end
        $display("op %s mode=%0d size=%0d words=%0d transfers=%0d", name, md, size, n, k);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        output_size = '0;
        output_buffer_ready = 1'b0;
        ready_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid_out, shift_enable, last_out, buffer_consumed, squeeze_request, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {valid_out, shift_enable, last_out, buffer_consumed, squeeze_request, done});
        end
        checks++;
        if (out_bits !== 7'd0) begin
            errors++;
            $display("FAIL reset_out_bits got=%0d exp=0", out_bits);
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
        end
        rst = 1'b0;
        $display("op reset released");
    endtask

    task automatic test_reset_mid_dump();
        @(negedge clk);
        start = 1'b1;
        mode = 1'b0;
        output_size = 32'd512;
        output_buffer_ready = 1'b1;
        ready_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        ready_in = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b1 || shift_enable !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_dump_pre valid=%b shift=%b exp=1 1", valid_out, shift_enable);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({valid_out, shift_enable, last_out, buffer_consumed, done} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_dump_async got=%b exp=00000",
                     {valid_out, shift_enable, last_out, buffer_consumed, done});
        end
        checks++;
        if (out_bits !== 7'd0 || stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_dump_counts out_bits=%0d stall=%0d exp=0 0", out_bits, stall_cycles);
        end
        @(negedge clk);
        rst = 1'b0;
        output_buffer_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (valid_out !== 1'b0 || done !== 1'b0 || buffer_consumed !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_dump_idle cycle=%0d valid=%b done=%b bc=%b exp=0 0 0",
                         i, valid_out, done, buffer_consumed);
            end
        end
        output_buffer_ready = 1'b0;
        $display("op reset mid-dump");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic md;
            int unsigned size;
            md = 1'($urandom_range(0, 1));
            if (i % 3 == 0) size = (md ? 17 : 21) * 64 * $urandom_range(1, 2);
            else size = $urandom_range(1, 3000);
            run_op(md, size, 1, 1'b0, "random");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        test_reset();
        run_op(1'b0, 256, 0, 1'b0, "single_block");
        run_op(1'b1, 1100, 0, 1'b0, "two_block");
        run_op(1'b0, 1344, 0, 1'b0, "exact_block");
        run_op(1'b1, 1088, 0, 1'b0, "exact_block_m1");
        run_op(1'b0, 256, 2, 1'b0, "backpressure");
        run_op(1'b0, 0, 0, 1'b0, "zero_length");
        run_op(1'b1, 1100, 1, 1'b1, "stray_start");
        test_reset_mid_dump();
        run_op(1'b0, 200, 1, 1'b0, "after_reset");
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
